// File: rtl/pipeline_latealu_if.sv
// Signal bundle between the ALU stage and the late-ALU stage.
// master drives the ALU-stage results; slave is the late-ALU stage itself.
interface pipeline_latealu_if;
    logic [4:0]  rd_index_in;
    logic [31:0] rd_value_in;
    logic        memop_disable_in;
    logic [2:0]  exception_in;
    logic        latealu_enable;
    logic [5:0]  latealu_op;
    logic [31:0] latealu_a0;
    logic [31:0] latealu_a1;
    logic [4:0]  rd_index;
    logic [31:0] rd_value;
    logic        memop_disable;
    logic [2:0]  exception;
    logic        stall;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    modport master (
        output rd_index_in, rd_value_in, memop_disable_in, exception_in,
               latealu_enable, latealu_op, latealu_a0, latealu_a1,
        input  rd_index, rd_value, memop_disable, exception, stall, hi_out, lo_out
    );

    modport slave (
        input  rd_index_in, rd_value_in, memop_disable_in, exception_in,
               latealu_enable, latealu_op, latealu_a0, latealu_a1,
        output rd_index, rd_value, memop_disable, exception, stall, hi_out, lo_out
    );
endinterface

// File: rtl/pipeline_latealu.sv
// Late-ALU pipeline stage: shifts, HI/LO moves, multiply and a 32-step
// restoring divider that stalls upstream while it iterates.
module pipeline_latealu #(
    parameter int DIV_CYCLES = 32
) (
    input logic               clk,
    input logic               rst,
    pipeline_latealu_if.slave bus
);
    localparam int CW = $clog2(DIV_CYCLES);

    localparam logic [5:0] OP_SRL   = 6'b000010;
    localparam logic [5:0] OP_SRA   = 6'b000011;
    localparam logic [5:0] OP_MFHI  = 6'b010000;
    localparam logic [5:0] OP_MTHI  = 6'b010001;
    localparam logic [5:0] OP_MFLO  = 6'b010010;
    localparam logic [5:0] OP_MTLO  = 6'b010011;
    localparam logic [5:0] OP_MULT  = 6'b011000;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_DIV   = 6'b011010;
    localparam logic [5:0] OP_DIVU  = 6'b011011;

    typedef enum logic {IDLE, DIV_BUSY} state_t;

    state_t      state_q, state_d;
    logic [4:0]  rd_index_q, rd_index_d;
    logic [31:0] rd_value_q, rd_value_d;
    logic        memop_disable_q, memop_disable_d;
    logic [2:0]  exception_q, exception_d;
    logic        stall_q, stall_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d, dvd_q, dvd_d, dvsr_q, dvsr_d, quo_q, quo_d;
    logic        neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d, dbz_q, dbz_d;

    logic [31:0] a0, a1;
    logic        div_signed;
    logic [31:0] a0_mag, a1_mag;
    logic [63:0] prod_s, prod_u;
    logic [32:0] rem_shift;
    logic        step_ge;
    logic [31:0] rem_diff, rem_next, quo_next, quo_fix, rem_fix;

    assign a0         = bus.latealu_a0;
    assign a1         = bus.latealu_a1;
    assign div_signed = (bus.latealu_op == OP_DIV);
    assign a0_mag     = (div_signed && a0[31]) ? -a0 : a0;
    assign a1_mag     = (div_signed && a1[31]) ? -a1 : a1;
    assign prod_s     = $signed({{32{a0[31]}}, a0}) * $signed({{32{a1[31]}}, a1});
    assign prod_u     = {32'd0, a0} * {32'd0, a1};

    // One restoring step: the partial remainder is always below the divisor,
    // so the subtraction result fits in 32 bits whenever it is taken.
    assign rem_shift = {rem_q, dvd_q[31]};
    assign step_ge   = (rem_shift >= {1'b0, dvsr_q});
    assign rem_diff  = rem_shift[31:0] - dvsr_q;
    assign rem_next  = step_ge ? rem_diff : rem_shift[31:0];
    assign quo_next  = {quo_q[30:0], step_ge};
    assign quo_fix   = neg_quo_q ? -quo_next : quo_next;
    assign rem_fix   = neg_rem_q ? -rem_next : rem_next;

    always_comb begin
        state_d         = state_q;
        rd_index_d      = rd_index_q;
        rd_value_d      = rd_value_q;
        memop_disable_d = memop_disable_q;
        exception_d     = exception_q;
        stall_d         = stall_q;
        hi_d            = hi_q;
        lo_d            = lo_q;
        cnt_d           = cnt_q;
        rem_d           = rem_q;
        dvd_d           = dvd_q;
        dvsr_d          = dvsr_q;
        quo_d           = quo_q;
        neg_quo_d       = neg_quo_q;
        neg_rem_d       = neg_rem_q;
        dbz_d           = dbz_q;

        case (state_q)
            IDLE: begin
                rd_index_d      = bus.rd_index_in;
                rd_value_d      = bus.rd_value_in;
                memop_disable_d = bus.memop_disable_in;
                exception_d     = bus.exception_in;
                stall_d         = 1'b0;
                if (bus.latealu_enable && bus.exception_in == 3'd0) begin
                    case (bus.latealu_op)
                        OP_SRL:  rd_value_d = a0 >> a1[4:0];
                        OP_SRA:  rd_value_d = $signed(a0) >>> a1[4:0];
                        OP_MFHI: rd_value_d = hi_q;
                        OP_MFLO: rd_value_d = lo_q;
                        OP_MTHI: begin hi_d = a0; rd_index_d = 5'd0; end
                        OP_MTLO: begin lo_d = a0; rd_index_d = 5'd0; end
                        OP_MULT: begin
                            hi_d = prod_s[63:32];
                            lo_d = prod_s[31:0];
                            rd_index_d = 5'd0;
                        end
                        OP_MULTU: begin
                            hi_d = prod_u[63:32];
                            lo_d = prod_u[31:0];
                            rd_index_d = 5'd0;
                        end
                        OP_DIV, OP_DIVU: begin
                            rd_index_d = 5'd0;
                            state_d    = DIV_BUSY;
                            stall_d    = 1'b1;
                            cnt_d      = '0;
                            rem_d      = 32'd0;
                            quo_d      = 32'd0;
                            dvd_d      = a0_mag;
                            dvsr_d     = a1_mag;
                            neg_quo_d  = div_signed && (a0[31] ^ a1[31]);
                            neg_rem_d  = div_signed && a0[31];
                            dbz_d      = (a1 == 32'd0);
                        end
                        default: begin
                            exception_d = 3'b001;
                            rd_index_d  = 5'd0;
                        end
                    endcase
                end
            end
            DIV_BUSY: begin
                rd_index_d      = 5'd0;
                rd_value_d      = 32'd0;
                memop_disable_d = 1'b1;
                exception_d     = 3'd0;
                stall_d         = 1'b1;
                rem_d           = rem_next;
                quo_d           = quo_next;
                dvd_d           = {dvd_q[30:0], 1'b0};
                cnt_d           = cnt_q + 1'b1;
                if (cnt_q == CW'(DIV_CYCLES - 1)) begin
                    // Divide by zero leaves the dividend in the remainder;
                    // the quotient is forced to all ones regardless of sign.
                    lo_d    = dbz_q ? 32'hFFFF_FFFF : quo_fix;
                    hi_d    = rem_fix;
                    stall_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            rd_index_q      <= '0;
            rd_value_q      <= '0;
            memop_disable_q <= 1'b0;
            exception_q     <= '0;
            stall_q         <= 1'b0;
            hi_q            <= '0;
            lo_q            <= '0;
            cnt_q           <= '0;
            rem_q           <= '0;
            dvd_q           <= '0;
            dvsr_q          <= '0;
            quo_q           <= '0;
            neg_quo_q       <= 1'b0;
            neg_rem_q       <= 1'b0;
            dbz_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            rd_index_q      <= rd_index_d;
            rd_value_q      <= rd_value_d;
            memop_disable_q <= memop_disable_d;
            exception_q     <= exception_d;
            stall_q         <= stall_d;
            hi_q            <= hi_d;
            lo_q            <= lo_d;
            cnt_q           <= cnt_d;
            rem_q           <= rem_d;
            dvd_q           <= dvd_d;
            dvsr_q          <= dvsr_d;
            quo_q           <= quo_d;
            neg_quo_q       <= neg_quo_d;
            neg_rem_q       <= neg_rem_d;
            dbz_q           <= dbz_d;
        end
    end

    assign bus.rd_index      = rd_index_q;
    assign bus.rd_value      = rd_value_q;
    assign bus.memop_disable = memop_disable_q;
    assign bus.exception     = exception_q;
    assign bus.stall         = stall_q;
    assign bus.hi_out        = hi_q;
    assign bus.lo_out        = lo_q;
endmodule

// File: doc/pipeline_latealu.md
Name: pipeline_latealu

Overview:
Pipeline stage directly downstream of the ALU stage. It consumes the ALU stage's registered outputs, executes the deferred "late" operations (srl/sra, mult/multu, div/divu, mfhi/mflo/mthi/mtlo) and owns the HI/LO registers. All other ALU results pass through unchanged. While an iterative divide runs, it raises `stall` so the hazard logic freezes upstream stages.

Parameters:
DIV_CYCLES, 32, number of radix-2 divide iterations; fixed at 32 for 32-bit operands.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rd_index_in  in  5  destination register index from ALU stage
rd_value_in  in  32  ALU result
memop_disable_in  in  1  memop kill flag from ALU stage
exception_in  in  3  exception code from ALU stage; 0 = none
latealu_enable  in  1  late op requested
latealu_op  in  6  late op code (MIPS funct)
latealu_a0  in  32  operand 0 (rs, or rt for shifts)
latealu_a1  in  32  operand 1 (rt, or shift amount in [4:0])
rd_index  out  5  registered destination index
rd_value  out  32  registered result
memop_disable  out  1  registered memop kill
exception  out  3  registered exception code
stall  out  1  registered; high while divide busy
hi_out  out  32  current HI (debug)
lo_out  out  32  current LO (debug)

Behaviour:
- Single clock `clk`. Reset `rst` is synchronous and active-high. Reset is honoured in any state, including mid-divide.
- Reset values: rd_index=0, rd_value=0, memop_disable=0, exception=0, stall=0, HI=0, LO=0, state=IDLE. Any in-progress divide is discarded.
- States: IDLE, DIV_BUSY.
- IDLE, latency 1. Every cycle, inputs are registered to the outputs:
  - rd_index ← rd_index_in; memop_disable ← memop_disable_in; exception ← exception_in.
  - rd_value ← rd_value_in, unless it is overridden by a late op.
- A late op executes only if latealu_enable=1 and exception_in=0. An exception suppresses any HI/LO update.
- Op codes:
  - 000010 srl: rd_value ← a0 >> a1[4:0] (logical).
  - 000011 sra: rd_value ← a0 >>> a1[4:0] (arithmetic).
  - 010000 mfhi: rd_value ← HI.
  - 010010 mflo: rd_value ← LO.
  - 010001 mthi: HI ← a0; rd_index ← 0.
  - 010011 mtlo: LO ← a0; rd_index ← 0.
  - 011000 mult: {HI,LO} ← signed 64-bit a0*a1, written at the accept edge; rd_index ← 0.
  - 011001 multu: same as mult, unsigned.
  - 011010 div / 011011 divu: latch operands, signedness and absolute values; rd_index ← 0; state → DIV_BUSY; stall ← 1; iteration counter ← 0.
  - Any other op with latealu_enable=1: exception ← 3'b001, rd_index ← 0.
- An mfhi/mflo in the cycle directly after mult/mthi/mtlo returns the new value. The write lands at the accept edge, and the read happens one cycle later.
- DIV_BUSY:
  - Runs one restoring-division step per cycle on the unsigned magnitudes.
  - All inputs are ignored; upstream holds them stable because stall=1.
  - Outputs are a bubble: rd_index=0, rd_value=0, memop_disable=1, exception=0.
  - At the edge completing iteration 32:
    - Apply sign fixup for div: quotient negated if the operand signs differ; remainder takes a0's sign.
    - LO ← quotient; HI ← remainder; stall ← 0; state → IDLE.
  - stall is therefore high for exactly 32 cycles. The held instruction is accepted on the first IDLE cycle.
- Divide boundary cases:
  - Divide by zero (a1=0), both div and divu: LO ← 0xFFFFFFFF, HI ← a0. Still takes 32 cycles.
  - div 0x80000000 / 0xFFFFFFFF: LO ← 0x80000000, HI ← 0. No exception.
- A divide issued while exception_in≠0 is not started; it passes through as a normal exception cycle.
- All arithmetic is 32-bit modulo unless stated otherwise; the multiply product is full 64-bit.

Test Plan:
- Shift pass-through: srl a0=0x80000010, a1=4 → rd_value=0x08000001 next cycle. sra with the same operands → 0xF8000001. Non-late add rd_value_in=5, rd_index_in=3 → rd_value=5, rd_index=3.
- mult/mfhi/mflo: mult a0=0xFFFFFFFE (−2), a1=3, then mfhi, then mflo → HI=0xFFFFFFFF, LO=0xFFFFFFFA; the mult output has rd_index=0.
- div signed: div a0=−7 (0xFFFFFFF9), a1=2 → stall high for exactly 32 cycles with bubble outputs; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. A held mflo issued during stall completes afterwards and returns 0xFFFFFFFD.
- div boundaries:
  - divu a0=10, a1=0 → LO=0xFFFFFFFF, HI=10.
  - div 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0, exception=0.
- Reset mid-divide: assert rst at busy cycle 10 → next cycle stall=0, HI=LO=0, outputs zero; a subsequent srl executes normally.
- Exception suppression and bad op:
  - mthi a0=0x1234 with exception_in=3'b010 → HI unchanged, exception=3'b010.
  - latealu_op=6'b111111 → exception=3'b001, rd_index=0.
